// File: rtl/cache_memory_requester_if.sv
// Port bundle between a cache controller / main memory and the line requester.
// "slave" is the requester's view; "master" is the controller-and-memory side.
interface cache_memory_requester_if #(
  parameter int ADDRESS_SIZE    = 12,
  parameter int CACHE_LINE_SIZE = 128
);
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic                       req_fill;
  logic [ADDRESS_SIZE-1:0]    req_wb_address;
  logic [ADDRESS_SIZE-1:0]    req_fill_address;
  logic [CACHE_LINE_SIZE-1:0] req_wb_data;
  logic                       resp_valid;
  logic [CACHE_LINE_SIZE-1:0] resp_data;
  logic                       busy;
  logic                       mem_write_enable;
  logic                       mem_read_enable;
  logic [ADDRESS_SIZE-1:0]    mem_address;
  logic [CACHE_LINE_SIZE-1:0] mem_data_in;
  logic [CACHE_LINE_SIZE-1:0] mem_data_out;

  modport slave (
    input  req_valid, req_write, req_fill, req_wb_address, req_fill_address,
           req_wb_data, mem_data_out,
    output req_ready, resp_valid, resp_data, busy, mem_write_enable,
           mem_read_enable, mem_address, mem_data_in
  );

  modport master (
    output req_valid, req_write, req_fill, req_wb_address, req_fill_address,
           req_wb_data, mem_data_out,
    input  req_ready, resp_valid, resp_data, busy, mem_write_enable,
           mem_read_enable, mem_address, mem_data_in
  );
endinterface

// File: rtl/cache_memory_requester.sv
// Line-granular writeback/fill sequencer in front of main memory.
// One request at a time; every output is a register.
module cache_memory_requester #(
  parameter int ADDRESS_SIZE    = 12,
  parameter int CACHE_LINE_SIZE = 128,
  parameter int MEMORY_LATENCY  = 5
) (
  input logic                     clk,
  input logic                     reset,
  cache_memory_requester_if.slave bus
);
  localparam int LB          = CACHE_LINE_SIZE / 8;
  localparam int OFFSET_BITS = (LB > 1) ? $clog2(LB) : 0;
  localparam int CW          = $clog2(MEMORY_LATENCY + 1);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WRITE      = 3'd1;
  localparam logic [2:0] ST_WRITE_WAIT = 3'd2;
  localparam logic [2:0] ST_READ       = 3'd3;
  localparam logic [2:0] ST_READ_WAIT  = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  localparam logic [CW-1:0] COUNT_LOAD = CW'(MEMORY_LATENCY);
  localparam logic [CW-1:0] COUNT_LAST = CW'(1);

  logic [2:0]                 state_reg, state_next;
  logic [CW-1:0]              count_reg, count_next;
  logic                       fill_flag_reg, fill_flag_next;
  logic [ADDRESS_SIZE-1:0]    fill_addr_reg, fill_addr_next;
  logic                       req_ready_reg, busy_reg, resp_valid_reg;
  logic                       wr_en_reg, wr_en_next;
  logic                       rd_en_reg, rd_en_next;
  logic [ADDRESS_SIZE-1:0]    addr_reg, addr_next;
  logic [CACHE_LINE_SIZE-1:0] data_in_reg, data_in_next;
  logic [CACHE_LINE_SIZE-1:0] resp_data_reg, resp_data_next;

  logic [ADDRESS_SIZE-1:0]    wb_aligned;
  logic [ADDRESS_SIZE-1:0]    fill_aligned;

  // Byte-offset bits are forced to zero: memory returns shifted data otherwise.
  for (genvar gi = 0; gi < ADDRESS_SIZE; gi++) begin : g_align
    if (gi < OFFSET_BITS) begin : g_offset
      assign wb_aligned[gi]   = 1'b0;
      assign fill_aligned[gi] = 1'b0;
    end else begin : g_line
      assign wb_aligned[gi]   = bus.req_wb_address[gi];
      assign fill_aligned[gi] = bus.req_fill_address[gi];
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    fill_flag_next = fill_flag_reg;
    fill_addr_next = fill_addr_reg;
    wr_en_next     = 1'b0;
    rd_en_next     = 1'b0;
    addr_next      = addr_reg;
    data_in_next   = data_in_reg;
    resp_data_next = resp_data_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          fill_flag_next = bus.req_fill;
          fill_addr_next = fill_aligned;
          if (bus.req_write) begin
            state_next   = ST_WRITE;
            wr_en_next   = 1'b1;
            addr_next    = wb_aligned;
            data_in_next = bus.req_wb_data;
          end else if (bus.req_fill) begin
            state_next = ST_READ;
            rd_en_next = 1'b1;
            addr_next  = fill_aligned;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        state_next = ST_WRITE_WAIT;
        count_next = COUNT_LOAD;
      end
      ST_WRITE_WAIT: begin
        if (count_reg <= COUNT_LAST) begin
          if (fill_flag_reg) begin
            state_next = ST_READ;
            rd_en_next = 1'b1;
            addr_next  = fill_addr_reg;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          count_next = count_reg - COUNT_LAST;
        end
      end
      ST_READ: begin
        state_next = ST_READ_WAIT;
        count_next = COUNT_LOAD;
      end
      ST_READ_WAIT: begin
        if (count_reg <= COUNT_LAST) begin
          state_next     = ST_DONE;
          resp_data_next = bus.mem_data_out;
        end else begin
          count_next = count_reg - COUNT_LAST;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs are derived from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      count_reg      <= '0;
      fill_flag_reg  <= 1'b0;
      fill_addr_reg  <= '0;
      req_ready_reg  <= 1'b1;
      busy_reg       <= 1'b0;
      resp_valid_reg <= 1'b0;
      wr_en_reg      <= 1'b0;
      rd_en_reg      <= 1'b0;
      addr_reg       <= '0;
      data_in_reg    <= '0;
      resp_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      fill_flag_reg  <= fill_flag_next;
      fill_addr_reg  <= fill_addr_next;
      req_ready_reg  <= (state_next == ST_IDLE);
      busy_reg       <= (state_next != ST_IDLE);
      resp_valid_reg <= (state_next == ST_DONE);
      wr_en_reg      <= wr_en_next;
      rd_en_reg      <= rd_en_next;
      addr_reg       <= addr_next;
      data_in_reg    <= data_in_next;
      resp_data_reg  <= resp_data_next;
    end
  end

  assign bus.req_ready        = req_ready_reg;
  assign bus.busy             = busy_reg;
  assign bus.resp_valid       = resp_valid_reg;
  assign bus.resp_data        = resp_data_reg;
  assign bus.mem_write_enable = wr_en_reg;
  assign bus.mem_read_enable  = rd_en_reg;
  assign bus.mem_address      = addr_reg;
  assign bus.mem_data_in      = data_in_reg;
endmodule

// File: tb/tb_cache_memory_requester.sv
// Bench for cache_memory_requester: directed table, reset/abort sequence,
// then random requests scored against a line-level reference model.
module tb_cache_memory_requester;
  localparam int AW = 12;
  localparam int DW = 128;
  localparam int L  = 5;
  localparam int LB = DW / 8;

  typedef struct {
    bit           wr;
    bit           fl;
    logic [AW-1:0] wba;
    logic [AW-1:0] fla;
    logic [DW-1:0] wbd;
    int            poke;        // cycle in which a stray req_valid is pulsed, 0 = none
    int            exp_wr_cyc;  // 0 = no write expected
    logic [AW-1:0] exp_wr_addr;
    int            exp_rd_cyc;  // 0 = no read expected
    logic [AW-1:0] exp_rd_addr;
    int            exp_resp_cyc;
    logic [DW-1:0] exp_resp_data;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_memory_requester_if #(.ADDRESS_SIZE(AW), .CACHE_LINE_SIZE(DW)) bus ();

  cache_memory_requester #(
    .ADDRESS_SIZE(AW), .CACHE_LINE_SIZE(DW), .MEMORY_LATENCY(L)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Bus-functional main memory: one line per aligned address, registered read.
  logic [DW-1:0] mem_array [0:(1<<AW)/LB-1];
  always @(posedge clk) begin
    if (bus.mem_write_enable) mem_array[bus.mem_address / LB] <= bus.mem_data_in;
    if (bus.mem_read_enable)  bus.mem_data_out <= mem_array[bus.mem_address / LB];
  end

  // Reference state: what memory should contain and what resp_data should hold.
  logic [DW-1:0] ref_mem [0:(1<<AW)/LB-1];
  logic [DW-1:0] ref_resp;

  int checks = 0;
  int errors = 0;
  vec_t vecs [4];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Builds the expected outcome of a request from the protocol's timing rules.
  task automatic model(inout vec_t v);
    logic [AW-1:0] wa, fa;
    wa = AW'((v.wba / LB) * LB);
    fa = AW'((v.fla / LB) * LB);
    v.exp_wr_cyc  = v.wr ? 1 : 0;
    v.exp_wr_addr = wa;
    v.exp_rd_cyc  = v.fl ? (v.wr ? L + 2 : 1) : 0;
    v.exp_rd_addr = fa;
    if (!v.wr && !v.fl)     v.exp_resp_cyc = 1;
    else if (v.wr && v.fl)  v.exp_resp_cyc = 2 * L + 3;
    else                    v.exp_resp_cyc = L + 2;
    if (v.wr) ref_mem[wa / LB] = v.wbd;
    if (v.fl) ref_resp = ref_mem[fa / LB];
    v.exp_resp_data = ref_resp;
  endtask

  task automatic do_request(input vec_t v, input string tag);
    int wr_n = 0, rd_n = 0, resp_n = 0, both_n = 0;
    int wr_c = 0, rd_c = 0, resp_c = 0;
    logic [AW-1:0] wr_a = '0, rd_a = '0;
    logic [DW-1:0] wr_d = '0, resp_d = '0;
    logic busy1 = 1'b0, ready_after = 1'b0;
    @(negedge clk);
    check({tag, " ready_before"}, DW'(bus.req_ready), DW'(1));
    bus.req_valid        = 1'b1;
    bus.req_write        = v.wr;
    bus.req_fill         = v.fl;
    bus.req_wb_address   = v.wba;
    bus.req_fill_address = v.fla;
    bus.req_wb_data      = v.wbd;
    @(posedge clk);
    for (int c = 1; c <= v.exp_resp_cyc + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_valid = 1'b0;
        busy1 = bus.busy;
      end
      if (bus.mem_write_enable && bus.mem_read_enable) both_n++;
      if (bus.mem_write_enable) begin
        wr_n++; if (wr_n == 1) begin wr_c = c; wr_a = bus.mem_address; wr_d = bus.mem_data_in; end
      end
      if (bus.mem_read_enable) begin
        rd_n++; if (rd_n == 1) begin rd_c = c; rd_a = bus.mem_address; end
      end
      if (bus.resp_valid) begin
        resp_n++; if (resp_n == 1) begin resp_c = c; resp_d = bus.resp_data; end
      end
      if (c == v.exp_resp_cyc + 1) ready_after = bus.req_ready;
      // Stray request while busy: garbage fields, must be dropped.
      if (v.poke != 0 && c == v.poke) begin
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_fill = 1'b1;
        bus.req_wb_address = AW'($urandom); bus.req_fill_address = AW'($urandom);
        bus.req_wb_data = rand_line();
      end
      if (v.poke != 0 && c == v.poke + 1) bus.req_valid = 1'b0;
    end
    check({tag, " busy_c1"}, DW'(busy1), DW'(1));
    check({tag, " enable_overlap"}, DW'(both_n), DW'(0));
    check({tag, " wr_pulses"}, DW'(wr_n), DW'(v.exp_wr_cyc != 0));
    if (v.exp_wr_cyc != 0) begin
      check({tag, " wr_cycle"}, DW'(wr_c), DW'(v.exp_wr_cyc));
      check({tag, " wr_addr"}, DW'(wr_a), DW'(v.exp_wr_addr));
      check({tag, " wr_data"}, wr_d, v.wbd);
    end
    check({tag, " rd_pulses"}, DW'(rd_n), DW'(v.exp_rd_cyc != 0));
    if (v.exp_rd_cyc != 0) begin
      check({tag, " rd_cycle"}, DW'(rd_c), DW'(v.exp_rd_cyc));
      check({tag, " rd_addr"}, DW'(rd_a), DW'(v.exp_rd_addr));
    end
    check({tag, " resp_pulses"}, DW'(resp_n), DW'(1));
    check({tag, " resp_cycle"}, DW'(resp_c), DW'(v.exp_resp_cyc));
    check({tag, " resp_data"}, resp_d, v.exp_resp_data);
    check({tag, " ready_after"}, DW'(ready_after), DW'(1));
    $display("req %s wr=%0d fl=%0d wba=%h fla=%h resp_cycle=%0d resp_data=%h",
             tag, v.wr, v.fl, v.wba, v.fla, resp_c, resp_d);
  endtask

  initial begin
    vec_t v;
    int resp_seen, rd_seen;
    for (int i = 0; i < (1<<AW)/LB; i++) begin
      mem_array[i] = '0;
      ref_mem[i]   = '0;
    end
    ref_resp = '0;
    bus.mem_data_out = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_fill = 1'b0;
    bus.req_wb_address = '0; bus.req_fill_address = '0; bus.req_wb_data = '0;

    vecs[0] = '{wr:1, fl:0, wba:12'h000, fla:12'h5A5, wbd:128'h00FF00FF_00FF00FF_00FF00FF_00FF00FF,
                poke:0, exp_wr_cyc:1, exp_wr_addr:12'h000, exp_rd_cyc:0, exp_rd_addr:12'h000,
                exp_resp_cyc:7, exp_resp_data:128'h0};
    vecs[1] = '{wr:0, fl:1, wba:12'h3C0, fla:12'h003, wbd:128'h1,
                poke:0, exp_wr_cyc:0, exp_wr_addr:12'h000, exp_rd_cyc:1, exp_rd_addr:12'h000,
                exp_resp_cyc:7, exp_resp_data:128'h00FF00FF_00FF00FF_00FF00FF_00FF00FF};
    vecs[2] = '{wr:1, fl:1, wba:12'h010, fla:12'h01C, wbd:128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D,
                poke:3, exp_wr_cyc:1, exp_wr_addr:12'h010, exp_rd_cyc:7, exp_rd_addr:12'h010,
                exp_resp_cyc:13, exp_resp_data:128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D};
    vecs[3] = '{wr:0, fl:0, wba:12'h020, fla:12'h030, wbd:128'h2,
                poke:0, exp_wr_cyc:0, exp_wr_addr:12'h000, exp_rd_cyc:0, exp_rd_addr:12'h000,
                exp_resp_cyc:1, exp_resp_data:128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D};

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst req_ready", DW'(bus.req_ready), DW'(1));
    check("rst busy", DW'(bus.busy), DW'(0));
    check("rst resp_valid", DW'(bus.resp_valid), DW'(0));
    check("rst wr_en", DW'(bus.mem_write_enable), DW'(0));
    check("rst rd_en", DW'(bus.mem_read_enable), DW'(0));
    check("rst mem_address", DW'(bus.mem_address), DW'(0));
    check("rst mem_data_in", bus.mem_data_in, DW'(0));
    check("rst resp_data", bus.resp_data, DW'(0));

    // Directed table; the reference memory is kept in step with it.
    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      if (v.wr) ref_mem[(v.wba / LB)] = v.wbd;
      if (v.fl) ref_resp = ref_mem[(v.fla / LB)];
      do_request(v, $sformatf("vec%0d", i));
    end

    // Fill aborted by reset during cycle 3.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_fill = 1'b1;
    bus.req_fill_address = 12'h010;
    @(posedge clk);
    @(negedge clk); bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("abort req_ready", DW'(bus.req_ready), DW'(1));
    check("abort busy", DW'(bus.busy), DW'(0));
    check("abort resp_valid", DW'(bus.resp_valid), DW'(0));
    check("abort rd_en", DW'(bus.mem_read_enable), DW'(0));
    check("abort resp_data", bus.resp_data, DW'(0));
    resp_seen = 0; rd_seen = 0;
    for (int c = 0; c < L + 4; c++) begin
      @(negedge clk);
      if (bus.resp_valid) resp_seen++;
      if (bus.mem_read_enable) rd_seen++;
    end
    check("abort no_resp", DW'(resp_seen), DW'(0));
    check("abort no_read", DW'(rd_seen), DW'(0));
    $display("req abort resp_pulses=%0d rd_pulses=%0d", resp_seen, rd_seen);
    ref_resp = '0;
    v = '{wr:0, fl:1, wba:12'h0, fla:12'h01F, wbd:128'h0, poke:0, exp_wr_cyc:0, exp_wr_addr:12'h0,
          exp_rd_cyc:0, exp_rd_addr:12'h0, exp_resp_cyc:0, exp_resp_data:128'h0};
    model(v);
    do_request(v, "after_abort");

    // Random traffic over a handful of lines so fills hit earlier writebacks.
    for (int i = 0; i < 40; i++) begin
      v.wr   = 1'($urandom);
      v.fl   = 1'($urandom);
      v.wba  = AW'($urandom_range(0, 127));
      v.fla  = AW'($urandom_range(0, 127));
      v.wbd  = rand_line();
      v.poke = ($urandom_range(0, 3) == 0) ? 2 : 0;
      model(v);
      if (v.poke > v.exp_resp_cyc - 1) v.poke = 0;
      do_request(v, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_memory_requester.md
# cache_memory_requester

Initiator-side sequencer that drives the `Memory` block's port group (`write_enable`, `read_enable`, `address`, `data_in`, `data_out`) on behalf of a cache controller. It accepts one line-granular request at a time:

- **writeback** of a dirty line,
- **fill** of a new line,
- or **both**, issued as writeback then fill.

It line-aligns the addresses, holds each memory access for a fixed latency, captures the fill data and returns a one-cycle response. It sits between the cache controllers and main memory.

## Interface
Parameters:
- `ADDRESS_SIZE`, default 12: byte address width.
- `CACHE_LINE_SIZE`, default 128: line width in bits; bytes per line `LB = CACHE_LINE_SIZE/8`.
- `MEMORY_LATENCY`, default 5: wait cycles after each memory access; legal range ≥ 1.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request offered.
- `req_ready` out 1: high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `req_write` in 1: perform a writeback.
- `req_fill` in 1: perform a fill.
- `req_wb_address` in ADDRESS_SIZE: writeback byte address.
- `req_fill_address` in ADDRESS_SIZE: fill byte address.
- `req_wb_data` in CACHE_LINE_SIZE: writeback line.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out CACHE_LINE_SIZE: last captured fill line.
- `busy` out 1: high in every state except IDLE.
- `mem_write_enable` out 1: drives `Memory.write_enable`.
- `mem_read_enable` out 1: drives `Memory.read_enable`.
- `mem_address` out ADDRESS_SIZE: drives `Memory.address`.
- `mem_data_in` out CACHE_LINE_SIZE: drives `Memory.data_in`.
- `mem_data_out` in CACHE_LINE_SIZE: from `Memory.data_out`.

## Operation
- **States:** IDLE, WRITE, WRITE_WAIT, READ, READ_WAIT, DONE. All outputs are registered.
- **Request latching:** on acceptance, latch all `req_*` fields. Inputs may then change freely.
- **Address alignment:** clear the low `log2(LB)` bits of both addresses before driving `mem_address` (e.g. 0x01F → 0x010). An unaligned line read from `Memory` returns shifted data, so the requester never issues one.
- **IDLE transitions on acceptance:**
  - `req_write` set → WRITE (writeback first, whether or not `req_fill` is set).
  - else `req_fill` set → READ.
  - else → DONE (null request).
- **WRITE** (1 cycle): `mem_write_enable=1`, `mem_address` = aligned writeback address, `mem_data_in` = latched data. Then → WRITE_WAIT.
- **WRITE_WAIT** (`MEMORY_LATENCY` cycles, enables low): then → READ if the fill flag is latched, else → DONE.
- **READ** (1 cycle): `mem_read_enable=1`, `mem_address` = aligned fill address. Then → READ_WAIT.
- **READ_WAIT** (`MEMORY_LATENCY` cycles): on its final edge, capture `mem_data_out` into `resp_data`. Then → DONE.
- **DONE** (1 cycle): `resp_valid=1`. Then → IDLE.
- **resp_data retention:**
  - Changes only on a fill capture.
  - Holds its value across write-only and null requests.
- **Wait counter:** width `$clog2(MEMORY_LATENCY+1)`. Loaded when entering a WAIT state, decremented each cycle; the WAIT state is left when the count reaches 1. It never wraps.
- **Address bus when idle:** `mem_address` and `mem_data_in` hold their last value when no enable is asserted.

## Timing
- **Cycle numbering:** the acceptance edge starts cycle 1. L = `MEMORY_LATENCY`.
- **Latencies:**
  - Write-only: WRITE in cycle 1, WRITE_WAIT in cycles 2..L+1, `resp_valid` in cycle L+2.
  - Fill-only: READ in cycle 1, capture at the end of cycle L+1, `resp_valid` in cycle L+2.
  - Write+fill: WRITE in cycle 1, READ in cycle L+2, `resp_valid` in cycle 2L+3.
  - Null request: `resp_valid` in cycle 1.
- **Back-to-back:** `req_ready` rises in the cycle after DONE. The minimum gap between acceptances is latency+1 cycles.
- **Enable exclusivity:** `mem_write_enable` and `mem_read_enable` are never high together. Each is high for exactly one cycle per access.
- **Reset values:** after any edge with `reset=1`:
  - Control outputs: state IDLE, `req_ready=1`, `busy=0`, `resp_valid=0`, `mem_write_enable=0`, `mem_read_enable=0`.
  - Data/address outputs: `mem_address=0`, `mem_data_in=0`, `resp_data=0`.
- **Reset behaviour:**
  - Reset has priority over acceptance.
  - Reset mid-operation aborts silently: no `resp_valid`, and enables are low from the next cycle.
  - A write already pulsed is not undone.
- **Ignored input:** `req_valid` while busy is ignored, not queued.

## Test plan
1. **Reset:** hold `reset` 2 cycles → `req_ready=1`, `busy=0`, all enables 0, `resp_data=0`.
2. **Write-only:** address 0x000, data 128'h00FF00FF_00FF00FF_00FF00FF_00FF00FF, L=5.
   - `mem_write_enable` high only in cycle 1 with `mem_address=0x000`.
   - `resp_valid` in cycle 7; `resp_data` still 0.
3. **Fill-only:** address 0x003 after test 2.
   - `mem_read_enable` in cycle 1 with `mem_address=0x000`.
   - `resp_valid` in cycle 7 with `resp_data`=128'h00FF00FF_00FF00FF_00FF00FF_00FF00FF.
4. **Write+fill:** writeback 0x010 ← 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, fill 0x01C.
   - Write in cycle 1, read at 0x010 in cycle 7.
   - `resp_valid` in cycle 13 with the DEADBEEF line.
5. **Reset mid-operation:** assert `reset` in cycle 3 of a fill → no `resp_valid`, `mem_read_enable` stays 0, `req_ready=1` next cycle; the next fill completes normally.
6. **Ignored request and null request:**
   - Pulse `req_valid` while `busy` → ignored; exactly one `resp_valid` seen.
   - Null request (both flags 0) → `resp_valid` in cycle 1, no memory enables.
